// File: rtl/sprite_pkg.sv
// Shared constants, attribute layout and FSM encoding for the sprite unit.
package sprite_pkg;

   localparam int unsigned NUM_SPRITES = 256;
   localparam int unsigned IDX_W       = 8;
   localparam int unsigned COORD_W     = 10;
   localparam int unsigned IMG_W       = 8;
   localparam int unsigned ACT_W       = 4;
   localparam int unsigned WDATA_W     = 14;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned ATTR_W      = 29;
   localparam int unsigned FMASK_W     = 4;

   // Field offsets within scan_attr
   localparam int unsigned X_LSB   = 0;
   localparam int unsigned Y_LSB   = 10;
   localparam int unsigned IMG_LSB = 20;
   localparam int unsigned EN_BIT  = 28;

   // Field write-mask bit positions
   localparam int unsigned FLD_X   = 0;
   localparam int unsigned FLD_Y   = 1;
   localparam int unsigned FLD_IMG = 2;
   localparam int unsigned FLD_EN  = 3;

   localparam logic [ACT_W-1:0] SPR_NOP     = 4'h0;
   localparam logic [ACT_W-1:0] SPR_SET_X   = 4'h1;
   localparam logic [ACT_W-1:0] SPR_SET_Y   = 4'h2;
   localparam logic [ACT_W-1:0] SPR_SET_IMG = 4'h3;
   localparam logic [ACT_W-1:0] SPR_SET_EN  = 4'h4;
   localparam logic [ACT_W-1:0] SPR_ADD_X   = 4'h5;
   localparam logic [ACT_W-1:0] SPR_ADD_Y   = 4'h6;
   localparam logic [ACT_W-1:0] SPR_RD_X    = 4'h7;
   localparam logic [ACT_W-1:0] SPR_RD_Y    = 4'h8;
   localparam logic [ACT_W-1:0] SPR_RD_IMG  = 4'h9;
   localparam logic [ACT_W-1:0] SPR_RD_EN   = 4'hA;

   typedef struct packed {
      logic               en;
      logic [IMG_W-1:0]   img;
      logic [COORD_W-1:0] y;
      logic [COORD_W-1:0] x;
   } sprite_attr_t;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_RMW   = 2'd2
   } spr_state_t;

   function automatic logic is_write_act(input logic [ACT_W-1:0] act);
      return (act >= SPR_SET_X) && (act <= SPR_ADD_Y);
   endfunction

   function automatic logic is_read_act(input logic [ACT_W-1:0] act);
      return (act >= SPR_RD_X) && (act <= SPR_RD_EN);
   endfunction

endpackage

// File: rtl/sprite_attr_ram.sv
// 256-entry sprite attribute RAM: read-first RW port A with per-field write
// enables, read-only port B. Contents are not reset; only read registers are.
module sprite_attr_ram
   import sprite_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [IDX_W-1:0]   addr_a,
   input  logic [FMASK_W-1:0] we_a,
   input  sprite_attr_t       wdata_a,
   output sprite_attr_t       rdata_a,
   input  logic [IDX_W-1:0]   addr_b,
   output sprite_attr_t       rdata_b
);

   logic [COORD_W-1:0] mem_x   [NUM_SPRITES];
   logic [COORD_W-1:0] mem_y   [NUM_SPRITES];
   logic [IMG_W-1:0]   mem_img [NUM_SPRITES];
   logic               mem_en  [NUM_SPRITES];

   always_ff @(posedge clk) begin
      if (we_a[FLD_X])   mem_x[addr_a]   <= wdata_a.x;
      if (we_a[FLD_Y])   mem_y[addr_a]   <= wdata_a.y;
      if (we_a[FLD_IMG]) mem_img[addr_a] <= wdata_a.img;
      if (we_a[FLD_EN])  mem_en[addr_a]  <= wdata_a.en;
   end

   // Non-blocking reads give old data on a same-cycle write (read-first)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         rdata_a.x   <= mem_x[addr_a];
         rdata_a.y   <= mem_y[addr_a];
         rdata_a.img <= mem_img[addr_a];
         rdata_a.en  <= mem_en[addr_a];
         rdata_b.x   <= mem_x[addr_b];
         rdata_b.y   <= mem_y[addr_b];
         rdata_b.img <= mem_img[addr_b];
         rdata_b.en  <= mem_en[addr_b];
      end
   end

endmodule

// File: rtl/sprite_unit.sv
// Sprite attribute command executor: post-reset clear sweep, single-cycle SETs,
// one-cycle read-modify-write for reads and ADDs, independent scan port.
module sprite_unit
   import sprite_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [ACT_W-1:0]    sprite_action,
   input  logic [IDX_W-1:0]    sprite_addr,
   input  logic [WDATA_W-1:0]  sprite_wdata,
   input  logic                sprite_re,
   input  logic                sprite_we,
   output logic                busy,
   output logic [DATA_W-1:0]   sprite_data,
   output logic                sprite_data_valid,
   input  logic [IDX_W-1:0]    scan_addr,
   output logic [ATTR_W-1:0]   scan_attr
);

   spr_state_t         state, state_d;
   logic [IDX_W-1:0]   clr_cnt;
   logic [ACT_W-1:0]   lat_action;
   logic [IDX_W-1:0]   lat_addr;
   logic [COORD_W-1:0] lat_wdata;

   logic [IDX_W-1:0]   ram_addr;
   logic [FMASK_W-1:0] ram_we;
   sprite_attr_t       ram_wdata, ram_rdata, scan_rdata;

   logic               is_wr, is_rd, rd_fire;
   logic [DATA_W-1:0]  rd_mux;
   logic               unused_wdata_hi;

   assign unused_wdata_hi = ^sprite_wdata[WDATA_W-1:COORD_W];
   assign scan_attr       = scan_rdata;

   // Write strobe wins over read strobe
   assign is_wr = sprite_we && is_write_act(sprite_action);
   assign is_rd = sprite_re && !sprite_we && is_read_act(sprite_action);

   always_comb begin
      state_d   = state;
      ram_addr  = sprite_addr;
      ram_we    = '0;
      ram_wdata = '0;
      case (state)
         ST_CLEAR: begin
            ram_addr = clr_cnt;
            ram_we   = '1;
            if (clr_cnt == IDX_W'(NUM_SPRITES - 1)) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (is_wr) begin
               case (sprite_action)
                  SPR_SET_X: begin
                     ram_we[FLD_X] = 1'b1;
                     ram_wdata.x   = sprite_wdata[COORD_W-1:0];
                  end
                  SPR_SET_Y: begin
                     ram_we[FLD_Y] = 1'b1;
                     ram_wdata.y   = sprite_wdata[COORD_W-1:0];
                  end
                  SPR_SET_IMG: begin
                     ram_we[FLD_IMG] = 1'b1;
                     ram_wdata.img   = sprite_wdata[IMG_W-1:0];
                  end
                  SPR_SET_EN: begin
                     ram_we[FLD_EN] = 1'b1;
                     ram_wdata.en   = sprite_wdata[0];
                  end
                  default: state_d = ST_RMW;
               endcase
            end else if (is_rd) begin
               state_d = ST_RMW;
            end
         end
         ST_RMW: begin
            ram_addr = lat_addr;
            state_d  = ST_IDLE;
            if (lat_action == SPR_ADD_X) begin
               ram_we[FLD_X] = 1'b1;
               ram_wdata.x   = ram_rdata.x + lat_wdata;
            end else if (lat_action == SPR_ADD_Y) begin
               ram_we[FLD_Y] = 1'b1;
               ram_wdata.y   = ram_rdata.y + lat_wdata;
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign rd_fire = (state == ST_RMW) && is_read_act(lat_action);

   always_comb begin
      rd_mux = '0;
      case (lat_action)
         SPR_RD_X:   rd_mux = DATA_W'(ram_rdata.x);
         SPR_RD_Y:   rd_mux = DATA_W'(ram_rdata.y);
         SPR_RD_IMG: rd_mux = DATA_W'(ram_rdata.img);
         SPR_RD_EN:  rd_mux = DATA_W'(ram_rdata.en);
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_CLEAR;
      else     state <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_cnt           <= '0;
         lat_action        <= SPR_NOP;
         lat_addr          <= '0;
         lat_wdata         <= '0;
         busy              <= 1'b1;
         sprite_data       <= '0;
         sprite_data_valid <= 1'b0;
      end else begin
         busy              <= (state_d != ST_IDLE);
         sprite_data_valid <= rd_fire;
         if (state == ST_CLEAR) clr_cnt <= clr_cnt + IDX_W'(1);
         if (state == ST_IDLE) begin
            lat_action <= sprite_action;
            lat_addr   <= sprite_addr;
            lat_wdata  <= sprite_wdata[COORD_W-1:0];
         end
         if (rd_fire) sprite_data <= rd_mux;
      end
   end

   sprite_attr_ram u_ram (
      .clk     (clk),
      .rst     (rst),
      .addr_a  (ram_addr),
      .we_a    (ram_we),
      .wdata_a (ram_wdata),
      .rdata_a (ram_rdata),
      .addr_b  (scan_addr),
      .rdata_b (scan_rdata)
   );

endmodule

// File: tb/tb_sprite_unit.sv
// Directed table-driven bench for sprite_unit plus hand-written multi-cycle sequences.
module tb_sprite_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sprite_action;
   logic [7:0]  sprite_addr;
   logic [13:0] sprite_wdata;
   logic        sprite_re, sprite_we;
   logic        busy;
   logic [31:0] sprite_data;
   logic        sprite_data_valid;
   logic [7:0]  scan_addr;
   logic [28:0] scan_attr;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0]  act;
      logic [7:0]  addr;
      logic [13:0] wdata;
      logic        re;
      logic        we;
      logic        exp_busy;
      int          exp_pulses;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   sprite_unit dut (
      .clk               (clk),
      .rst               (rst),
      .sprite_action     (sprite_action),
      .sprite_addr       (sprite_addr),
      .sprite_wdata      (sprite_wdata),
      .sprite_re         (sprite_re),
      .sprite_we         (sprite_we),
      .busy              (busy),
      .sprite_data       (sprite_data),
      .sprite_data_valid (sprite_data_valid),
      .scan_addr         (scan_addr),
      .scan_attr         (scan_attr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, want);
      end
   endtask

   task automatic drive(input logic [3:0] act, input logic [7:0] addr, input logic [13:0] wd,
                        input logic re, input logic we);
      sprite_action = act;
      sprite_addr   = addr;
      sprite_wdata  = wd;
      sprite_re     = re;
      sprite_we     = we;
   endtask

   task automatic idle_inputs();
      drive(4'h0, 8'h00, 14'h0, 1'b0, 1'b0);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy !== 1'b0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (n >= 600) chk("idle_timeout", 32'(busy), 32'h0);
   endtask

   // Counts cycles with busy high, starting at the negedge where rst was released
   task automatic count_clear(input string name);
      int cnt = 0;
      while (busy === 1'b1 && cnt < 400) begin
         cnt++;
         @(negedge clk);
      end
      chk(name, 32'(cnt), 32'd256);
   endtask

   task automatic scan_chk(input string name, input logic [7:0] a, input logic [28:0] want);
      scan_addr = a;
      @(negedge clk);
      chk(name, 32'(scan_attr), 32'(want));
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          pulses = 0;
      logic [31:0] data = '0;
      wait_idle();
      drive(v.act, v.addr, v.wdata, v.re, v.we);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk($sformatf("v%0d_busy", idx), 32'(busy), 32'(v.exp_busy));
      repeat (3) begin
         if (sprite_data_valid === 1'b1) begin
            pulses++;
            data = sprite_data;
         end
         @(negedge clk);
      end
      chk($sformatf("v%0d_pulses", idx), 32'(pulses), 32'(v.exp_pulses));
      if (v.exp_pulses != 0) chk($sformatf("v%0d_data", idx), data, v.exp_data);
   endtask

   initial begin
      int          pulses;
      logic [31:0] data;

      //            act    addr   wdata     re    we    busy  pulses data
      vecs.push_back('{4'h1, 8'd5,  14'h3FF, 1'b0, 1'b1, 1'b0, 0, 32'h0});
      vecs.push_back('{4'h7, 8'd5,  14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h3FF});
      vecs.push_back('{4'h2, 8'd7,  14'd10,  1'b0, 1'b1, 1'b0, 0, 32'h0});
      vecs.push_back('{4'h6, 8'd7,  14'h3FE, 1'b0, 1'b1, 1'b1, 0, 32'h0});
      vecs.push_back('{4'h8, 8'd7,  14'h000, 1'b1, 1'b0, 1'b1, 1, 32'd8});
      vecs.push_back('{4'h6, 8'd7,  14'h3F0, 1'b0, 1'b1, 1'b1, 0, 32'h0});
      vecs.push_back('{4'h8, 8'd7,  14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h3F8});
      vecs.push_back('{4'h3, 8'd9,  14'h3AB, 1'b0, 1'b1, 1'b0, 0, 32'h0});
      vecs.push_back('{4'h9, 8'd9,  14'h000, 1'b1, 1'b0, 1'b1, 1, 32'hAB});
      vecs.push_back('{4'h4, 8'd3,  14'h001, 1'b1, 1'b1, 1'b0, 0, 32'h0});
      vecs.push_back('{4'hA, 8'd3,  14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h1});
      vecs.push_back('{4'hC, 8'd3,  14'h000, 1'b0, 1'b1, 1'b0, 0, 32'h0});
      vecs.push_back('{4'hA, 8'd3,  14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h1});
      vecs.push_back('{4'h1, 8'd5,  14'h000, 1'b1, 1'b0, 1'b0, 0, 32'h0});
      vecs.push_back('{4'h7, 8'd5,  14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h3FF});
      vecs.push_back('{4'h1, 8'd20, 14'h155, 1'b0, 1'b1, 1'b0, 0, 32'h0});
      vecs.push_back('{4'h5, 8'd20, 14'h2AB, 1'b0, 1'b1, 1'b1, 0, 32'h0});
      vecs.push_back('{4'h7, 8'd20, 14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h0});
      vecs.push_back('{4'h7, 8'd5,  14'h000, 1'b1, 1'b1, 1'b0, 0, 32'h0});
      vecs.push_back('{4'h9, 8'd0,  14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h0});

      rst = 1'b1;
      idle_inputs();
      scan_addr = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy",  32'(busy), 32'h1);
      chk("rst_valid", 32'(sprite_data_valid), 32'h0);
      chk("rst_data",  sprite_data, 32'h0);
      chk("rst_scan",  32'(scan_attr), 32'h0);
      rst = 1'b0;
      count_clear("clear_len");
      scan_chk("scan_0",   8'd0,   29'h0);
      scan_chk("scan_128", 8'd128, 29'h0);
      scan_chk("scan_255", 8'd255, 29'h0);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // Same-cycle write and scan of entry 5: scan sees old then new data
      wait_idle();
      drive(4'h1, 8'd5, 14'h111, 1'b0, 1'b1);
      scan_addr = 8'd5;
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      chk("scan_read_first", 32'(scan_attr), 32'h3FF);
      @(negedge clk);
      chk("scan_new", 32'(scan_attr), 32'h111);

      // RD_IMG presented during an ADD's RMW and held until accepted
      pulses = 0;
      data   = '0;
      wait_idle();
      drive(4'h5, 8'd9, 14'h001, 1'b0, 1'b1);
      @(posedge clk);
      @(negedge clk);
      chk("held_busy_rmw", 32'(busy), 32'h1);
      drive(4'h9, 8'd9, 14'h000, 1'b1, 1'b0);
      @(negedge clk);
      chk("held_busy_idle", 32'(busy), 32'h0);
      if (sprite_data_valid === 1'b1) pulses++;
      @(negedge clk);
      idle_inputs();
      repeat (3) begin
         if (sprite_data_valid === 1'b1) begin
            pulses++;
            data = sprite_data;
         end
         @(negedge clk);
      end
      chk("held_pulses", 32'(pulses), 32'd1);
      chk("held_data", data, 32'hAB);
      run_vec('{4'h7, 8'd9, 14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h1}, 100);

      // Reset during an ADD_X RMW drops the write and restarts the sweep
      wait_idle();
      drive(4'h5, 8'd5, 14'h0FF, 1'b0, 1'b1);
      @(posedge clk);
      #1 rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      chk("rmw_rst_busy", 32'(busy), 32'h1);
      @(negedge clk);
      rst = 1'b0;
      count_clear("clear_len_2");
      run_vec('{4'hA, 8'd5, 14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h0}, 101);
      run_vec('{4'h7, 8'd5, 14'h000, 1'b1, 1'b0, 1'b1, 1, 32'h0}, 102);
      scan_chk("scan_after_rst", 8'd5, 29'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sprite_unit.md
# sprite_unit

Sprite attribute store and command executor sitting directly downstream of the execute stage. It consumes the sprite command fields execute produces: action, 8-bit sprite index, 14-bit write data, read/write enables. It applies each command to a 256-entry attribute memory and returns read results to the writeback path. A second, independent read port feeds the renderer. After reset it sweeps every entry to "disabled" and holds the pipeline off with `busy` meanwhile.

## Interface
- `NUM_SPRITES`, 256: entries; index width is 8 bits, fixed.
- `COORD_W`, 10: width of the X and Y coordinates.
- `clk` in 1: single clock; every state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sprite_action` in 4: command code.
- `sprite_addr` in 8: sprite index.
- `sprite_wdata` in 14: immediate or register value selected by execute.
- `sprite_re` in 1: read-class command strobe.
- `sprite_we` in 1: write-class command strobe.
- `busy` out 1: command not accepted this cycle; upstream stalls and holds its inputs.
- `sprite_data` out 32: read result, zero-extended.
- `sprite_data_valid` out 1: one-cycle pulse marking `sprite_data` valid.
- `scan_addr` in 8: renderer index.
- `scan_attr` out 29: renderer attributes `{en, img[7:0], y[9:0], x[9:0]}`.

## Operation
- Each entry holds four fields: `x[9:0]`, `y[9:0]`, `img[7:0]`, `en`.
- Write-class actions require `sprite_we=1`; read-class actions require `sprite_re=1`. An action with the wrong strobe is a NOP.
- Write-class actions:
  - 0x1 SET_X: `x<=wdata[9:0]`.
  - 0x2 SET_Y: `y<=wdata[9:0]`.
  - 0x3 SET_IMG: `img<=wdata[7:0]`.
  - 0x4 SET_EN: `en<=wdata[0]`.
  - 0x5 ADD_X: `x<=x+wdata[9:0]` mod 1024 (two's-complement wrap, no saturation).
  - 0x6 ADD_Y: same rule applied to `y`.
- Read-class actions: 0x7 RD_X, 0x8 RD_Y, 0x9 RD_IMG, 0xA RD_EN.
- Codes 0x0 and 0xB–0xF are NOP.
- `re` and `we` both high: `we` wins, the action is decoded as write-class, and no read is performed.
- FSM states:
  - CLEAR: entered from reset. Counter runs 0..255 writing `en=0` (x, y, img also zeroed), one entry per cycle. Moves to IDLE after entry 255.
  - IDLE: accepts commands. SET_* and NOP complete here. RD_* and ADD_* move to RMW.
  - RMW: one cycle. RAM read data is available. Reads drive `sprite_data` and pulse valid. ADDs write the sum. Always returns to IDLE.
- `busy` = state≠IDLE. Inputs presented while `busy=1` are ignored; upstream holds them and they are accepted in the first IDLE cycle.
- A command accepted in IDLE latches its action, index and data. RMW uses only these latched copies.
- The scan port is a separate read port. It never stalls and never affects `busy`.
- Write/scan collision on the same index in the same cycle: scan returns old data (read-first).

## Timing
- Reset values: state=CLEAR, clear counter=0, `busy=1`, `sprite_data=0`, `sprite_data_valid=0`, `scan_attr=0`.
- After `rst` deasserts, `busy` stays high for exactly 256 cycles.
- Reset asserted mid-operation (CLEAR or RMW) aborts immediately. Any pending RMW write is dropped and the sweep restarts at index 0.
- SET_*: write lands at the accept edge. Zero stall cycles; the next command can be accepted on the following cycle.
- RD_*: accepted at edge N. `sprite_data` and valid are driven from edge N+1 and held for one cycle. `busy=1` for one cycle.
- ADD_*: accepted at edge N, sum written at edge N+1, `busy=1` for one cycle.
- A read issued right after a SET or ADD to the same entry returns the new value, so no hazard is visible upstream.
- Scan port: `scan_addr` sampled at edge N, `scan_attr` valid after edge N (one-cycle registered latency) and held until the next edge.

## Structure
- Shared package `sprite_pkg`:
  - action code constants `SPR_SET_X` … `SPR_RD_EN`;
  - `COORD_W`;
  - field offsets within `scan_attr`;
  - FSM state encoding.
- One sub-module: `sprite_attr_ram`, a 256×29 simple dual-port synchronous RAM. It has a read-first port A (read/write, command side) and a read-only port B (scan). Vendor-memory friendly; no reset on contents.
- FSM, clear counter, command latch, adder and read mux live in `sprite_unit`.

## Test plan
- Reset, then release → `busy` high for exactly 256 cycles. Scanning indices 0, 128 and 255 returns `scan_attr=0`.
- SET_X(idx 5, 0x3FF), then RD_X(5) next cycle → `busy` pulses one cycle, `sprite_data=0x000003FF` with valid one cycle after accept.
- SET_Y(7, 10), then ADD_Y(7, 0x3FE) (−2) → RD_Y returns 8. Then ADD_Y(7, 0x3F0) → wraps to 0x3F8.
- RD_IMG presented during RMW of a previous ADD and held → accepted one cycle late. Exactly one valid pulse, correct data.
- `re=we=1` with SET_EN(3, 1) → `en[3]=1` and no `sprite_data_valid`. Action 0xC with `we=1` → no state change.
- Assert `rst` during ADD_X RMW → no write occurs, CLEAR restarts, and after 256 cycles the entry reads back `en=0`.
